// File: rtl/exhaustive_sweep_capture.sv
// exhaustive_sweep_capture
//   Walks every 2^IN_W input pattern into an external block, holds each one
//   for SETTLE cycles, samples the response, streams the pattern/response
//   pair out over a valid/ready handshake, and folds every response into a
//   MISR so two netlists can be compared by a single signature word.
//
// Ports
//   CK         in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a sweep (honoured in IDLE or DONE only)
//   abort      in   return to IDLE on the next edge
//   pat_out    out  [IN_W]    pattern applied to the block under test
//   dut_resp   in   [OUT_W]   response of the block under test
//   res_valid  out  result pair available
//   res_ready  in   consumer accepts the result pair
//   res_pat    out  [IN_W]    pattern of the presented result
//   res_data   out  [OUT_W]   captured response of the presented result
//   signature  out  [SIG_W]   running MISR value
//   pat_count  out  [IN_W+1]  results accepted so far
//   busy       out  high in DRIVE, CAPTURE, EMIT
//   done       out  high in DONE
//
// State     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start
// S_DRIVE   | pattern applied, settle down-counter running
// S_CAPTURE | sample response, update MISR, raise res_valid
// S_EMIT    | hold result until res_ready
// S_DONE    | sweep complete, signature and count frozen

module exhaustive_sweep_capture #(
  parameter int               IN_W   = 2,
  parameter int               OUT_W  = 1,
  parameter int               SETTLE = 1,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  pat_out,
  input  logic [OUT_W-1:0] dut_resp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IN_W-1:0]  res_pat,
  output logic [OUT_W-1:0] res_data,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W:0]    pat_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Down-counter load value: DRIVE lasts SETTLE cycles, ending when it hits 0.
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [IN_W-1:0] LAST_PAT    = {IN_W{1'b1}};
  localparam logic [IN_W:0]   ONE_CNT     = {{IN_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic [7:0]       settle_q;
  logic [IN_W:0]    pat_q;
  logic             res_valid_q;
  logic [IN_W-1:0]  res_pat_q;
  logic [OUT_W-1:0] res_data_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [IN_W:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             last_pat;

  // MISR step: shift, fold the MSB back through POLY, inject the response.
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ SIG_W'(dut_resp);
  end

  assign last_pat = (pat_q[IN_W-1:0] == LAST_PAT);

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      pat_q       <= '0;
      res_valid_q <= 1'b0;
      res_pat_q   <= '0;
      res_data_q  <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      // Signature and count are kept so a partial sweep can be inspected.
      state_q     <= S_IDLE;
      settle_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_DRIVE;
            settle_q <= SETTLE_LOAD;
            pat_q    <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (settle_q == 8'd0) begin
            state_q <= S_CAPTURE;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        S_CAPTURE: begin
          res_data_q  <= dut_resp;
          res_pat_q   <= pat_q[IN_W-1:0];
          sig_q       <= sig_d;
          res_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + ONE_CNT;
            if (last_pat) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pat_q    <= pat_q + ONE_CNT;
              settle_q <= SETTLE_LOAD;
              state_q  <= S_DRIVE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_out   = pat_q[IN_W-1:0];
  assign res_valid = res_valid_q;
  assign res_pat   = res_pat_q;
  assign res_data  = res_data_q;
  assign signature = sig_q;
  assign pat_count = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: instance A (IN_W=2, SETTLE=1, 4-bit
// MISR, POLY=3, response = XOR of pattern bits) and instance B (IN_W=4,
// SETTLE=3, constant-zero response). Expected result pairs go into per-
// instance queues; monitors pop and compare on every accepted handshake.

module tb_exhaustive_sweep_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct packed {
    logic [3:0] pat;
    logic       data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A
  logic       reset_a, start_a, abort_a, res_ready_a;
  logic [1:0] pat_out_a, res_pat_a;
  logic       dut_resp_a, res_valid_a, res_data_a;
  logic [3:0] signature_a;
  logic [2:0] pat_count_a;
  logic       busy_a, done_a;

  assign dut_resp_a = pat_out_a[1] ^ pat_out_a[0];

  exhaustive_sweep_capture #(
    .IN_W(2), .OUT_W(1), .SETTLE(1), .SIG_W(4), .POLY(4'h3)
  ) u_dut_a (
    .CK(CK), .reset(reset_a), .start(start_a), .abort(abort_a),
    .pat_out(pat_out_a), .dut_resp(dut_resp_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a),
    .res_pat(res_pat_a), .res_data(res_data_a),
    .signature(signature_a), .pat_count(pat_count_a),
    .busy(busy_a), .done(done_a)
  );

  // Instance B
  logic        reset_b, start_b, abort_b, res_ready_b;
  logic [3:0]  pat_out_b, res_pat_b;
  logic        dut_resp_b, res_valid_b, res_data_b;
  logic [15:0] signature_b;
  logic [4:0]  pat_count_b;
  logic        busy_b, done_b;

  assign dut_resp_b = 1'b0;

  exhaustive_sweep_capture #(
    .IN_W(4), .OUT_W(1), .SETTLE(3), .SIG_W(16), .POLY(16'h1021)
  ) u_dut_b (
    .CK(CK), .reset(reset_b), .start(start_b), .abort(abort_b),
    .pat_out(pat_out_b), .dut_resp(dut_resp_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_pat(res_pat_b), .res_data(res_data_b),
    .signature(signature_b), .pat_count(pat_count_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a result is consumed when valid&&ready is seen
  // between edges, i.e. the handshake completes on the following edge.
  always @(negedge CK) begin
    exp_t e;
    if (!reset_a && !abort_a && res_valid_a && res_ready_a) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_result: got pat %0h data %0h, expected none", res_pat_a, res_data_a);
      end else begin
        e = qa.pop_front();
        chk("a_res_pat", 32'(res_pat_a), 32'(e.pat));
        chk("a_res_data", 32'(res_data_a), 32'(e.data));
      end
    end
  end

  always @(negedge CK) begin
    exp_t e;
    if (!reset_b && !abort_b && res_valid_b && res_ready_b) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_result: got pat %0h data %0h, expected none", res_pat_b, res_data_b);
      end else begin
        e = qb.pop_front();
        chk("b_res_pat", 32'(res_pat_b), 32'(e.pat));
        chk("b_res_data", 32'(res_data_b), 32'(e.data));
      end
    end
  end

  // Hand-computed responses for patterns 0..3 of A: 0,1,1,0.
  logic [3:0] resp_a_tbl;

  task automatic push_full_a();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.pat  = 4'(i);
      e.data = resp_a_tbl[i];
      qa.push_back(e);
    end
  endtask

  task automatic pulse_start_a();
    @(posedge CK); #1 start_a = 1'b1;
    @(posedge CK); #1 start_a = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen (0 on timeout).
  task automatic wait_done_a(output int cyc);
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge CK); #1;
      if (done_a) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic wait_pat_a(input logic [1:0] p);
    for (int n = 0; n < 50; n++) begin
      @(posedge CK); #1;
      if (pat_out_a == p) break;
    end
    chk("a_wait_pat", 32'(pat_out_a), 32'(p));
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_pat_out"},   32'(pat_out_a),   32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid_a), 32'd0);
    chk({tag, "_res_pat"},   32'(res_pat_a),   32'd0);
    chk({tag, "_res_data"},  32'(res_data_a),  32'd0);
    chk({tag, "_signature"}, 32'(signature_a), 32'd0);
    chk({tag, "_pat_count"}, 32'(pat_count_a), 32'd0);
    chk({tag, "_busy"},      32'(busy_a),      32'd0);
    chk({tag, "_done"},      32'(done_a),      32'd0);
  endtask

  initial begin
    int   c;
    exp_t e;
    resp_a_tbl  = 4'b0110;
    reset_a     = 1'b1;
    start_a     = 1'b0;
    abort_a     = 1'b0;
    res_ready_a = 1'b1;
    reset_b     = 1'b1;
    start_b     = 1'b0;
    abort_b     = 1'b0;
    res_ready_b = 1'b1;

    repeat (3) @(posedge CK);
    #1;
    chk_zero_a("rst");
    chk("rst_b_signature", 32'(signature_b), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Full sweep, ready held high
    push_full_a();
    pulse_start_a();
    wait_done_a(c);
    chk("t1_done_latency", 32'(c), 32'd12);
    chk("t1_signature", 32'(signature_a), 32'h6);
    chk("t1_pat_count", 32'(pat_count_a), 32'd4);
    chk("t1_busy", 32'(busy_a), 32'd0);
    chk("t1_queue_empty", 32'(qa.size()), 32'd0);

    // Back-pressure on the second result
    push_full_a();
    pulse_start_a();
    wait_pat_a(2'd1);
    res_ready_a = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (res_valid_a) break;
      @(posedge CK); #1;
    end
    chk("t2_valid_seen", 32'(res_valid_a), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(posedge CK); #1;
      chk("t2_hold_valid", 32'(res_valid_a), 32'd1);
      chk("t2_hold_pat", 32'(res_pat_a), 32'd1);
      chk("t2_hold_data", 32'(res_data_a), 32'd1);
      chk("t2_hold_pat_out", 32'(pat_out_a), 32'd1);
      chk("t2_hold_count", 32'(pat_count_a), 32'd1);
    end
    res_ready_a = 1'b1;
    wait_done_a(c);
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_signature", 32'(signature_a), 32'h6);
    chk("t2_pat_count", 32'(pat_count_a), 32'd4);

    // Abort in DRIVE of pattern 10
    push_full_a();
    pulse_start_a();
    wait_pat_a(2'd2);
    abort_a = 1'b1;
    @(posedge CK); #1 abort_a = 1'b0;
    chk("t3_res_valid", 32'(res_valid_a), 32'd0);
    chk("t3_busy", 32'(busy_a), 32'd0);
    chk("t3_done", 32'(done_a), 32'd0);
    chk("t3_pat_count", 32'(pat_count_a), 32'd2);
    chk("t3_queue_left", 32'(qa.size()), 32'd2);
    qa.delete();
    push_full_a();
    pulse_start_a();
    chk("t3_restart_pat_out", 32'(pat_out_a), 32'd0);
    chk("t3_restart_signature", 32'(signature_a), 32'd0);
    chk("t3_restart_pat_count", 32'(pat_count_a), 32'd0);
    chk("t3_restart_busy", 32'(busy_a), 32'd1);
    wait_done_a(c);
    chk("t3_done_latency", 32'(c), 32'd12);
    chk("t3_signature", 32'(signature_a), 32'h6);

    // Reset during EMIT of the first result
    push_full_a();
    pulse_start_a();
    for (int n = 0; n < 20; n++) begin
      @(posedge CK); #1;
      if (res_valid_a) break;
    end
    chk("t4_in_emit", 32'(res_valid_a), 32'd1);
    reset_a = 1'b1;
    @(posedge CK); #1;
    chk_zero_a("t4_rst");
    reset_a = 1'b0;
    qa.delete();
    push_full_a();
    pulse_start_a();
    wait_done_a(c);
    chk("t4_done_latency", 32'(c), 32'd12);
    chk("t4_signature", 32'(signature_a), 32'h6);
    chk("t4_pat_count", 32'(pat_count_a), 32'd4);

    // start while busy is ignored; start in DONE restarts
    push_full_a();
    pulse_start_a();
    c = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge CK); #1;
      start_a = (n == 4);
      if (done_a) begin
        c = n;
        break;
      end
    end
    start_a = 1'b0;
    chk("t6_busy_start_latency", 32'(c), 32'd12);
    chk("t6_signature", 32'(signature_a), 32'h6);
    push_full_a();
    pulse_start_a();
    chk("t6_done_drops", 32'(done_a), 32'd0);
    chk("t6_busy", 32'(busy_a), 32'd1);
    chk("t6_pat_out", 32'(pat_out_a), 32'd0);
    chk("t6_signature_clr", 32'(signature_a), 32'd0);
    chk("t6_pat_count_clr", 32'(pat_count_a), 32'd0);
    wait_done_a(c);
    chk("t6_done_latency", 32'(c), 32'd12);
    chk("t6_final_signature", 32'(signature_a), 32'h6);

    // Instance B: 16 patterns, SETTLE=3, constant zero response
    for (int i = 0; i < 16; i++) begin
      e.pat  = 4'(i);
      e.data = 1'b0;
      qb.push_back(e);
    end
    @(posedge CK); #1 start_b = 1'b1;
    @(posedge CK); #1 start_b = 1'b0;
    c = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CK); #1;
      if (done_b) begin
        c = n;
        break;
      end
    end
    chk("t5_done_latency", 32'(c), 32'd80);
    chk("t5_signature", 32'(signature_b), 32'd0);
    chk("t5_pat_count", 32'(pat_count_b), 32'd16);
    chk("t5_queue_empty", 32'(qb.size()), 32'd0);
    chk("final_a_queue_empty", 32'(qa.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
